// File: rtl/flag_xfer_pkg.sv
// Shared types and helpers for the flag transfer arbiter: FSM encoding and a
// ceiling-log2 usable in parameter expressions.
package flag_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } xfer_state_t;

    // Never returns less than 1 so single-entry ranges still get a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/flag_xfer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick
    import flag_xfer_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDW = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic [IDW-1:0]   grant,
    output logic             any
);

    int idx;

    // Scan from farthest to nearest so the nearest set request is written last.
    always_comb begin
        grant = '0;
        idx   = 0;
        any   = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (req[idx]) grant = IDW'(idx);
        end
    end

endmodule

// File: rtl/flag_xfer_arbiter.sv
// Shares one flag crossing between N_REQ event sources: one transfer in flight,
// round-robin grant, ack/timeout completion and an idle gap between pulses.
module flag_xfer_arbiter
    import flag_xfer_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255,
    parameter int GAP_CYC = 2,
    localparam int IDW = clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             ack_flag,
    output logic             xfer_flag,
    output logic [IDW-1:0]   xfer_id,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] done_pulse,
    output logic [N_REQ-1:0] overflow,
    output logic             timeout_err
);

    localparam int WW = clog2(TIMEOUT + 1);
    localparam int GW = clog2(GAP_CYC + 1);

    xfer_state_t      state, state_nxt;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   winner;
    logic             any_pend;
    logic [WW-1:0]    wait_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [N_REQ-1:0] id_onehot;
    logic [N_REQ-1:0] clr_vec;
    logic             wait_limit;
    logic             gap_last;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req   (pending),
        .last  (last_grant),
        .grant (winner),
        .any   (any_pend)
    );

    assign id_onehot  = N_REQ'(1) << xfer_id;
    assign clr_vec    = (state == SEND) ? id_onehot : '0;
    assign wait_limit = (wait_cnt == WW'(TIMEOUT));
    assign gap_last   = (gap_cnt == GW'(GAP_CYC - 1));
    assign xfer_flag  = (state == SEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_pend) state_nxt = SEND;
            SEND:     state_nxt = WAIT_ACK;
            WAIT_ACK: if (ack_flag || wait_limit) state_nxt = GAP;
            GAP:      if (gap_last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // A request landing on the bit SEND is clearing re-arms it rather than overflowing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            last_grant  <= IDW'(N_REQ - 1);
            xfer_id     <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            done_pulse  <= '0;
            overflow    <= '0;
            timeout_err <= 1'b0;
        end else begin
            pending  <= (pending & ~clr_vec) | req_pulse;
            overflow <= req_pulse & pending & ~clr_vec;
            if (state == IDLE && any_pend) begin
                xfer_id    <= winner;
                last_grant <= winner;
            end
            wait_cnt    <= (state == WAIT_ACK) ? wait_cnt + 1'b1 : '0;
            gap_cnt     <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            done_pulse  <= (state == WAIT_ACK && ack_flag) ? id_onehot : '0;
            timeout_err <= (state == WAIT_ACK) && !ack_flag && wait_limit;
        end
    end

endmodule

// File: tb/tb_flag_xfer_arbiter.sv
// Scoreboard bench for flag_xfer_arbiter: expected grants/completions are queued
// as stimulus is driven and consumed when the DUT emits them.
module tb_flag_xfer_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 8;
    localparam int GAP_CYC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_pulse;
    logic       ack_flag = 1'b0;
    logic       xfer_flag;
    logic [1:0] xfer_id;
    logic [3:0] pending;
    logic [3:0] done_pulse;
    logic [3:0] overflow;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_dly  = 0;
    int ack_cd   = -1;
    int t0;

    int         grant_q[$];
    logic [3:0] done_q[$];
    logic [3:0] ovf_q[$];
    int         to_q[$];
    int         xfer_log[$];

    flag_xfer_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_pulse   (req_pulse),
        .ack_flag    (ack_flag),
        .xfer_flag   (xfer_flag),
        .xfer_id     (xfer_id),
        .pending     (pending),
        .done_pulse  (done_pulse),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Return-crossing model: ack comes back ack_dly cycles after xfer_flag (0 = never).
    always @(negedge clk) begin
        ack_flag = 1'b0;
        if (ack_cd == 0) ack_flag = 1'b1;
        if (ack_cd >= 0) ack_cd--;
        if (xfer_flag && ack_dly > 0) ack_cd = ack_dly - 1;
    end

    always @(negedge clk) begin
        if (xfer_flag) begin
            xfer_log.push_back(cyc);
            check_eq("xfer_expected", grant_q.size() > 0, 1);
            if (grant_q.size() > 0) check_eq("xfer_id", xfer_id, grant_q.pop_front());
        end
        if (done_pulse != 4'b0) begin
            check_eq("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) check_eq("done_vec", done_pulse, done_q.pop_front());
        end
        if (overflow != 4'b0) begin
            check_eq("ovf_expected", ovf_q.size() > 0, 1);
            if (ovf_q.size() > 0) check_eq("ovf_vec", overflow, ovf_q.pop_front());
        end
        if (timeout_err) begin
            check_eq("timeout_expected", to_q.size() > 0, 1);
            if (to_q.size() > 0) check_eq("timeout_cyc", cyc, to_q.pop_front());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        xfer_log.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_pulse = 4'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_xfer_flag", xfer_flag, 0);
        check_eq("rst_xfer_id", xfer_id, 0);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_done", done_pulse, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        // Single request, ack 8 cycles after the pulse.
        ack_dly = 8;
        @(negedge clk);
        req_pulse = 4'b0100; t0 = cyc;
        grant_q.push_back(2); done_q.push_back(4'b0100);
        @(negedge clk);
        req_pulse = 4'b0;
        check_eq("a_pending", pending, 4'b0100);
        check_eq("a_no_flag_yet", xfer_flag, 0);
        @(negedge clk);
        check_eq("a_flag_cyc", cyc - t0, 2);
        check_eq("a_flag", xfer_flag, 1);
        check_eq("a_id", xfer_id, 2);
        @(negedge clk);
        check_eq("a_pending_clr", pending, 0);
        repeat (8) @(negedge clk);
        check_eq("a_done", done_pulse, 4'b0100);
        check_eq("a_id_hold", xfer_id, 2);
        repeat (4) @(negedge clk);

        // All four at once after reset: order 0,1,2,3, nine cycles apart.
        do_reset();
        ack_dly = 5;
        @(negedge clk);
        req_pulse = 4'b1111; t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            grant_q.push_back(i);
            done_q.push_back(4'(1 << i));
        end
        @(negedge clk);
        req_pulse = 4'b0;
        repeat (40) @(negedge clk);
        check_eq("b_xfer_count", xfer_log.size(), 4);
        if (xfer_log.size() == 4) begin
            check_eq("b_first_cyc", xfer_log[0] - t0, 2);
            for (int i = 1; i < 4; i++)
                check_eq("b_sep", xfer_log[i] - xfer_log[i-1], 1 + 5 + GAP_CYC + 1);
        end

        // Double request while busy: one overflow, one transfer for requester 1.
        ack_dly = 6;
        @(negedge clk);
        req_pulse = 4'b1000;
        grant_q.push_back(3); done_q.push_back(4'b1000);
        grant_q.push_back(1); done_q.push_back(4'b0010);
        ovf_q.push_back(4'b0010);
        @(negedge clk); req_pulse = 4'b0;
        repeat (3) @(negedge clk);
        req_pulse = 4'b0010;
        @(negedge clk); req_pulse = 4'b0;
        @(negedge clk); req_pulse = 4'b0010;
        @(negedge clk); req_pulse = 4'b0;
        check_eq("c_overflow", overflow, 4'b0010);
        check_eq("c_pending", pending, 4'b0010);
        repeat (16) @(negedge clk);

        // Request arriving in the SEND cycle of the same requester re-arms it.
        ack_dly = 3;
        @(negedge clk);
        req_pulse = 4'b0001;
        grant_q.push_back(0); done_q.push_back(4'b0001);
        grant_q.push_back(0); done_q.push_back(4'b0001);
        @(negedge clk); req_pulse = 4'b0;
        @(negedge clk);
        check_eq("d_send", xfer_flag, 1);
        req_pulse = 4'b0001;
        @(negedge clk); req_pulse = 4'b0;
        check_eq("d_pending_kept", pending, 4'b0001);
        check_eq("d_no_overflow", overflow, 0);
        repeat (14) @(negedge clk);

        // No ack: timeout 10 cycles after SEND, then idle again.
        ack_dly = 0;
        @(negedge clk);
        req_pulse = 4'b0100; t0 = cyc;
        grant_q.push_back(2);
        to_q.push_back(t0 + 12);
        @(negedge clk); req_pulse = 4'b0;
        repeat (11) @(negedge clk);
        check_eq("e_timeout", timeout_err, 1);
        check_eq("e_no_done", done_pulse, 0);
        repeat (2) @(negedge clk);
        check_eq("e_pending", pending, 0);
        // Ack on the very cycle the counter reaches TIMEOUT: ack wins.
        ack_dly = 9;
        req_pulse = 4'b1000;
        grant_q.push_back(3); done_q.push_back(4'b1000);
        @(negedge clk); req_pulse = 4'b0;
        @(negedge clk);
        check_eq("e_idle_flag", xfer_flag, 1);
        check_eq("e_idle_id", xfer_id, 3);
        repeat (10) @(negedge clk);
        check_eq("e_tie_done", done_pulse, 4'b1000);
        check_eq("e_tie_no_timeout", timeout_err, 0);
        repeat (3) @(negedge clk);

        // Reset during WAIT_ACK, ack lands two cycles later and is ignored.
        ack_dly = 4;
        req_pulse = 4'b0010;
        grant_q.push_back(1);
        @(negedge clk); req_pulse = 4'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("f_rst_pending", pending, 0);
        check_eq("f_rst_flag", xfer_flag, 0);
        check_eq("f_rst_id", xfer_id, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("f_late_done", done_pulse, 0);
        check_eq("f_late_timeout", timeout_err, 0);
        ack_dly = 2;
        req_pulse = 4'b0101;
        grant_q.push_back(0); done_q.push_back(4'b0001);
        grant_q.push_back(2); done_q.push_back(4'b0100);
        @(negedge clk); req_pulse = 4'b0;
        @(negedge clk);
        check_eq("f_first_after_rst", xfer_id, 0);
        repeat (20) @(negedge clk);

        check_eq("grant_q_left", grant_q.size(), 0);
        check_eq("done_q_left", done_q.size(), 0);
        check_eq("ovf_q_left", ovf_q.size(), 0);
        check_eq("to_q_left", to_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_xfer_arbiter.md
FLAG_XFER_ARBITER -- requirements
Module: flag_xfer_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one flag_sync crossing channel (2..16).
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT_ACK cycles before the transfer is abandoned.
REQ-003 Parameter GAP_CYC, default 2: minimum idle cycles between successive xfer_flag pulses.
REQ-004 Derived IDW = clog2(N_REQ).
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 Port clk  in  1  sole clock.
REQ-007 Port rst  in  1  asynchronous, active-high reset.
REQ-008 Port req_pulse  in  N_REQ  one-cycle event request per requester.
REQ-009 Port ack_flag  in  1  one-cycle acknowledge from the return crossing, already in clk domain.
REQ-010 Port xfer_flag  out  1  one-cycle pulse to the forward crossing's flag input.
REQ-011 Port xfer_id  out  IDW  requester index of the current transfer, registered.
REQ-012 Port pending  out  N_REQ  per-requester pending bits.
REQ-013 Port done_pulse  out  N_REQ  one-cycle completion pulse per requester.
REQ-014 Port overflow  out  N_REQ  one-cycle pulse when a request merges into an already-set pending bit.
REQ-015 Port timeout_err  out  1  one-cycle pulse when a transfer is abandoned.

Function
REQ-016 FSM states: IDLE, SEND, WAIT_ACK, GAP.
REQ-017 IDLE: if any pending bit is set, latch the round-robin winner into xfer_id and go to SEND; otherwise stay in IDLE.
REQ-018 Round-robin search starts at last_grant+1 mod N_REQ; last_grant updates on entry to SEND.
REQ-019 SEND lasts exactly one cycle: xfer_flag=1, the winner's pending bit clears, then go to WAIT_ACK.
REQ-020 req_pulse[i] sets pending[i] at the next edge.
REQ-021 req_pulse[i] arriving while pending[i]=1 (and pending[i] is not being cleared) raises overflow[i] the next cycle and is merged into the existing request.
REQ-022 req_pulse[i] in the same cycle SEND clears pending[i]: pending[i] stays 1, no overflow.
REQ-023 From an idle FSM, xfer_flag asserts exactly 2 cycles after the req_pulse cycle.
REQ-024 xfer_id holds stable from SEND until the cycle after leaving WAIT_ACK.
REQ-025 WAIT_ACK, counter behaviour: a wait counter (width clog2(TIMEOUT+1)) clears on entry and increments each cycle.
REQ-026 WAIT_ACK, on ack_flag=1: done_pulse[xfer_id]=1 the next cycle, then go to GAP.
REQ-027 WAIT_ACK, on counter==TIMEOUT without ack: timeout_err=1 the next cycle, no done_pulse, then go to GAP; the event is not retried.
REQ-028 ack_flag coinciding with counter==TIMEOUT: ack wins; done_pulse fires, no timeout_err.
REQ-029 GAP lasts GAP_CYC cycles, then go to IDLE, so toggle-based crossings never merge adjacent pulses.
REQ-030 ack_flag outside WAIT_ACK is ignored with no output effect.
REQ-031 At most one transfer is outstanding at any time; xfer_flag is never asserted outside SEND.

Reset
REQ-032 On rst=1 the block enters IDLE asynchronously.
REQ-033 Reset values: pending=0, last_grant=N_REQ-1 (requester 0 wins first), wait counter=0, xfer_id=0, and all outputs (xfer_flag, done_pulse, overflow, timeout_err) 0.
REQ-034 Reset mid-transfer drops all pending and in-flight events; a late ack after reset is ignored per REQ-030.

Structure
REQ-035 State encoding and IDW/clog2 helper live in shared package flag_xfer_pkg.
REQ-036 Round-robin selection is a combinational sub-module rr_pick with ports req vector, last index, grant index, and any-valid.
REQ-037 The block contains no flag_sync instance; the forward and return crossings are instantiated by the parent.

Verification
REQ-038 req_pulse=4'b0100 at cycle 0 -> pending[2]=1 at cycle 1; xfer_flag=1 with xfer_id=2 at cycle 2; ack_flag at cycle 10 -> done_pulse=4'b0100 at cycle 11.
REQ-039 req_pulse=4'b1111 in one cycle with acks returned after 5 cycles -> grants issue in order 0,1,2,3, each xfer_flag separated by at least 1+5+GAP_CYC cycles.
REQ-040 req_pulse[1] twice while pending[1]=1 -> one overflow[1] pulse and only one transfer for requester 1.
REQ-041 No ack, TIMEOUT=8 -> timeout_err at SEND+10, no done_pulse, FSM back in IDLE after GAP, pending[i]=0.
REQ-042 rst asserted during WAIT_ACK with ack delivered 2 cycles later -> all outputs 0, no done_pulse; the next request is granted to requester 0.
